// File: rtl/riscv_wb_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes and FSM state type.
package riscv_wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: selects byte/half/word from an aligned memory
// word and applies sign or zero extension. Unlisted funct3 codes behave as LW.
module load_extend
  import riscv_wb_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword (halfword ignores off[0]).
  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  // Apply extension according to the load type.
  always_comb begin
    data = word;
    case (f3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: owns the register-file write port, tracks one outstanding
// load, formats load data and reports RAW hazards to decode.
// Optional macro WB_BYPASS_EN: forward the staged write to decode instead of
// stalling on it.
module writeback_stage
  import riscv_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic                  ex_is_load,
  input  logic [2:0]            ex_load_f3,
  input  logic [1:0]            ex_byte_off,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] rw_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_hazard,
  output logic                  rs2_hazard
`ifdef WB_BYPASS_EN
  ,
  output logic                  rs1_fwd,
  output logic                  rs2_fwd,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data
`endif
);

  wb_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pend_rd_reg, pend_rd_next;
  logic [2:0]            pend_f3_reg, pend_f3_next;
  logic [1:0]            pend_off_reg, pend_off_next;
  logic                  wr_en_reg, wr_en_next;
  logic [ADDR_WIDTH-1:0] rw_addr_reg, rw_addr_next;
  logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
  logic [DATA_WIDTH-1:0] load_data;

  load_extend u_load_extend (
    .f3   (pend_f3_reg),
    .off  (pend_off_reg),
    .word (mem_rsp_data),
    .data (load_data)
  );

  // State and write-port registers; reset drops any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pend_rd_reg  <= '0;
      pend_f3_reg  <= '0;
      pend_off_reg <= '0;
      wr_en_reg    <= 1'b0;
      rw_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      pend_rd_reg  <= pend_rd_next;
      pend_f3_reg  <= pend_f3_next;
      pend_off_reg <= pend_off_next;
      wr_en_reg    <= wr_en_next;
      rw_addr_reg  <= rw_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  // Next-state logic: ALU results write next cycle, loads park in WAIT_RSP.
  // Writes to x0 complete normally but never raise wr_en.
  always_comb begin
    state_next    = state_reg;
    pend_rd_next  = pend_rd_reg;
    pend_f3_next  = pend_f3_reg;
    pend_off_next = pend_off_reg;
    wr_en_next    = 1'b0;
    rw_addr_next  = rw_addr_reg;
    wr_data_next  = wr_data_reg;
    case (state_reg)
      IDLE: begin
        if (ex_valid) begin
          if (ex_is_load) begin
            pend_rd_next  = ex_rd;
            pend_f3_next  = ex_load_f3;
            pend_off_next = ex_byte_off;
            state_next    = WAIT_RSP;
          end else begin
            wr_en_next   = (ex_rd != '0);
            rw_addr_next = ex_rd;
            wr_data_next = ex_data;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          wr_en_next   = (pend_rd_reg != '0);
          rw_addr_next = pend_rd_reg;
          wr_data_next = load_data;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ex_ready = (state_reg == IDLE);
  assign wr_en    = wr_en_reg;
  assign rw_addr  = rw_addr_reg;
  assign wr_data  = wr_data_reg;

  logic load_hz1, load_hz2, staged_hit1, staged_hit2;
  assign load_hz1    = (state_reg == WAIT_RSP) && (rs1_addr == pend_rd_reg) && (pend_rd_reg != '0);
  assign load_hz2    = (state_reg == WAIT_RSP) && (rs2_addr == pend_rd_reg) && (pend_rd_reg != '0);
  assign staged_hit1 = wr_en_reg && (rw_addr_reg == rs1_addr) && (rs1_addr != '0);
  assign staged_hit2 = wr_en_reg && (rw_addr_reg == rs2_addr) && (rs2_addr != '0);

`ifdef WB_BYPASS_EN
  assign rs1_hazard   = load_hz1;
  assign rs2_hazard   = load_hz2;
  assign rs1_fwd      = staged_hit1;
  assign rs2_fwd      = staged_hit2;
  assign rs1_fwd_data = wr_data_reg;
  assign rs2_fwd_data = wr_data_reg;
`else
  assign rs1_hazard = load_hz1 | staged_hit1;
  assign rs2_hazard = load_hz2 | staged_hit2;
`endif

endmodule
